// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA colour test design: RGB565 pixel
// struct, named colours, pattern mode encoding and the bar colour lookup.
package vga_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } pixel_t;

    localparam pixel_t WHITE     = pixel_t'(16'hFFFF);
    localparam pixel_t YELLOW    = pixel_t'(16'hFFE0);
    localparam pixel_t CYAN      = pixel_t'(16'h07FF);
    localparam pixel_t GREEN     = pixel_t'(16'h07E0);
    localparam pixel_t MAGENTA   = pixel_t'(16'hF81F);
    localparam pixel_t RED       = pixel_t'(16'hF800);
    localparam pixel_t BLUE      = pixel_t'(16'h001F);
    localparam pixel_t BLACK     = pixel_t'(16'h0000);
    localparam pixel_t BORDER_BG = pixel_t'(16'h0010);

    typedef enum logic [1:0] {
        MODE_BARS   = 2'd0,
        MODE_GRAD   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_BORDER = 2'd3
    } mode_e;

    function automatic pixel_t bar_colour(input logic [2:0] idx);
        pixel_t c;
        case (idx)
            3'd0:    c = WHITE;
            3'd1:    c = YELLOW;
            3'd2:    c = CYAN;
            3'd3:    c = GREEN;
            3'd4:    c = MAGENTA;
            3'd5:    c = RED;
            3'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Button conditioner: 2-flop synchroniser, consecutive-cycle debounce counter
// and a one-cycle pulse on every accepted press (high-to-low) transition.
module key_debounce #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                // this cycle is the CYCLES-th consecutive mismatch
                cnt   <= '0;
                level <= sync2;
                press <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage RGB565 test-pattern pipeline with button-selected mode applied at frame start.
// Define VGA_PATTERN_ANIMATE_EN to scroll the gradient and checker patterns one pixel per frame.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE        = 1440,
    parameter int   V_ACTIVE        = 900,
    parameter logic SYNC_ACTIVE     = 1'b1,
    parameter int   DEBOUNCE_CYCLES = 1_000_000,
    parameter int   CHECK_LOG2      = 5
) (
    input  logic        pixel_clock,
    input  logic        reset,
    input  logic        key_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    input  logic [10:0] x_in,
    input  logic [10:0] y_in,
    output logic        hsync,
    output logic        vsync,
    output logic [4:0]  r,
    output logic [5:0]  g,
    output logic [4:0]  b,
    output logic [1:0]  mode
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BCW   = $clog2(BAR_W + 1);

    logic           key_press;
    logic           key_level_unused;
    mode_e          mode_q;
    logic           pending;
    logic           frame_start;

    logic [10:0]    x1;
    logic [10:0]    y1;
    logic           de1;
    logic           hs1;
    logic           vs1;
    logic [2:0]     bar1;
    logic [BCW-1:0] bar_cnt;
    logic [2:0]     bar_idx;
    logic           de_rise;
    logic [BCW-1:0] cur_cnt;
    logic [2:0]     cur_idx;

    logic [10:0]    xs;
    logic           unused_xs;
    logic           on_border;
    pixel_t         pix_next;
    pixel_t         pix_q;

    key_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_key (
        .clock (pixel_clock),
        .reset (reset),
        .key_n (key_n),
        .level (key_level_unused),
        .press (key_press)
    );

    assign frame_start = (vsync_in == SYNC_ACTIVE) && (vs1 != SYNC_ACTIVE);

    // Presses coalesce in pending; a press landing on frame start waits a frame.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            mode_q  <= MODE_BARS;
            pending <= 1'b0;
        end else if (frame_start) begin
            if (pending) begin
                mode_q <= mode_e'(mode_q + 2'd1);
            end
            pending <= key_press;
        end else if (key_press) begin
            pending <= 1'b1;
        end
    end

`ifdef VGA_PATTERN_ANIMATE_EN
    logic [7:0] frame_cnt;

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

    always_comb begin
        de_rise = de_in & ~de1;
        cur_cnt = de_rise ? '0 : bar_cnt;
        cur_idx = de_rise ? 3'd0 : bar_idx;
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            x1      <= '0;
            y1      <= '0;
            de1     <= 1'b0;
            hs1     <= ~SYNC_ACTIVE;
            vs1     <= ~SYNC_ACTIVE;
            bar1    <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
        end else begin
            x1   <= x_in;
            y1   <= y_in;
            de1  <= de_in;
            hs1  <= hsync_in;
            vs1  <= vsync_in;
            bar1 <= cur_idx;
            if (de_in) begin
                if (cur_cnt == BCW'(BAR_W - 1)) begin
                    bar_cnt <= '0;
                    bar_idx <= (cur_idx == 3'd7) ? cur_idx : cur_idx + 3'd1;
                end else begin
                    bar_cnt <= cur_cnt + 1'b1;
                    bar_idx <= cur_idx;
                end
            end
        end
    end

    always_comb begin
`ifdef VGA_PATTERN_ANIMATE_EN
        xs = x1 + {3'd0, frame_cnt};
`else
        xs = x1;
`endif
        on_border = (x1 == 11'd0) || (x1 == 11'(H_ACTIVE - 1)) ||
                    (y1 == 11'd0) || (y1 == 11'(V_ACTIVE - 1));
        pix_next  = BLACK;
        if (de1) begin
            case (mode_q)
                MODE_BARS:   pix_next = bar_colour(bar1);
                MODE_GRAD:   pix_next = '{r: xs[7:3], g: xs[7:2], b: xs[7:3]};
                MODE_CHECK:  pix_next = (xs[CHECK_LOG2] ^ y1[CHECK_LOG2]) ? WHITE : BLACK;
                MODE_BORDER: pix_next = on_border ? WHITE : BORDER_BG;
                default:     pix_next = BLACK;
            endcase
        end
    end

    assign unused_xs = ^xs;

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            pix_q <= BLACK;
            hsync <= ~SYNC_ACTIVE;
            vsync <= ~SYNC_ACTIVE;
        end else begin
            pix_q <= pix_next;
            hsync <= hs1;
            vsync <= vs1;
        end
    end

    assign r    = pix_q.r;
    assign g    = pix_q.g;
    assign b    = pix_q.b;
    assign mode = mode_q;

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Pixel-colour stage for the VGA colour test design. Sits directly downstream of the sync/timing generator and directly upstream of the VGA pins. Consumes pixel coordinates, data-enable and syncs, and produces RGB565 test patterns (colour bars, gradient, checkerboard, border). The active pattern is selected by a debounced board button, and a new selection takes effect only at frame start.

## Interface
- `H_ACTIVE`, 1440: visible pixels per line.
- `V_ACTIVE`, 900: visible lines per frame.
- `SYNC_ACTIVE`, 1: active level of `hsync_in`/`vsync_in`.
- `DEBOUNCE_CYCLES`, 1_000_000: stable cycles required to accept a key level (~9.4 ms at 106.5 MHz).
- `CHECK_LOG2`, 5: checker square size is 2^CHECK_LOG2 pixels.

Ports:
- `pixel_clock` in 1: pixel clock, the only clock.
- `reset` in 1: asynchronous, active-high.
- `key_n` in 1: raw button, low = pressed, asynchronous to `pixel_clock`.
- `hsync_in` in 1: hsync from the timing stage.
- `vsync_in` in 1: vsync from the timing stage.
- `de_in` in 1: visible-area flag.
- `x_in` in 11: column, valid while `de_in`=1.
- `y_in` in 11: line, valid while `de_in`=1.
- `hsync` out 1: `hsync_in` delayed 2 cycles.
- `vsync` out 1: `vsync_in` delayed 2 cycles.
- `r` out 5, `g` out 6, `b` out 5: pixel colour.
- `mode` out 2: currently applied pattern, for LEDs.

## Operation
- Key path:
  - 2-flop synchroniser, then debounce counter.
  - The counter counts consecutive cycles in which the synced level differs from the accepted level, and clears when they match.
  - When the count reaches `DEBOUNCE_CYCLES`, the accepted level updates and the counter clears.
  - An accepted 1→0 transition sets `pending`.
- Frame start is the cycle in which `vsync_in` enters `SYNC_ACTIVE`.
  - At frame start, if `pending`=1: `mode <= mode+1` (wraps 3→0) and `pending` clears.
  - Any number of presses within one frame coalesce into a single increment.
- Pattern modes:
  - 0 colour bars: 8 bars of width `BAR_W = H_ACTIVE/8`, in order white, yellow, cyan, green, magenta, red, blue, black. The bar index comes from a column counter that clears on the `de_in` rising edge and advances the index each `BAR_W` pixels. The index saturates at 7, which absorbs any remainder.
  - 1 gradient: `r=x[7:3]`, `g=x[7:2]`, `b=x[7:3]`, a grey ramp that wraps every 256 px.
  - 2 checker: white when `x[CHECK_LOG2]^y[CHECK_LOG2]`=1, else black.
  - 3 border: white on `x==0`, `x==H_ACTIVE-1`, `y==0` or `y==V_ACTIVE-1`; elsewhere `r=0`, `g=0`, `b=16`.
- Colour values: white = 31/63/31; primary components are full scale or 0.
- Blanking: `r`, `g` and `b` are forced to 0 whenever the delayed `de` is 0.

## Timing
- Stage 1 registers `x`, `y`, `de`, syncs and bar index. Stage 2 registers the colour.
- Latency is 2 cycles, `x_in`→`r/g/b`. Syncs and `de` are delayed by exactly 2 cycles to stay aligned.
- `mode` changes only in the frame-start cycle, which lies in vertical blanking, so no frame ever mixes two patterns.
- Press-to-`mode` latency: 2 (sync) + `DEBOUNCE_CYCLES` + up to one frame.
- Key release and press bounces shorter than `DEBOUNCE_CYCLES` are ignored.
- Reset (any time, including mid-frame):
  - `hsync`, `vsync` ← `!SYNC_ACTIVE`.
  - `r`, `g`, `b`, `mode` ← 0.
  - `pending`, debounce counter, bar counter ← 0; accepted key level ← 1.
- After reset release, outputs are valid from the 2nd cycle.
- A press accepted in the same cycle as frame start sets `pending`, which is applied at the following frame start.

## Configuration
- `VGA_PATTERN_ANIMATE_EN` defined:
  - An 8-bit frame counter increments at every frame start and wraps 255→0.
  - Modes 1 and 2 use `x+frame_cnt` (11-bit, wrap) in place of `x`, so the pattern scrolls left 1 px/frame.
  - Modes 0 and 3 are unaffected.
- Undefined: no frame counter exists and all patterns are static.

## Structure
- Shared package `vga_pkg`:
  - RGB565 colour constants (`WHITE`, `YELLOW`, ... `BLACK`).
  - Mode encoding `MODE_BARS=0`, `MODE_GRAD=1`, `MODE_CHECK=2`, `MODE_BORDER=3`.
  - Struct typedef for a 16-bit pixel.
- Sub-module `key_debounce`: synchroniser, debounce counter and press-pulse output. It is reusable for other board buttons.
- Pattern selection and the pipeline live in the top of this block.

## Test plan
- Reset asserted mid-line → next edge gives `r/g/b=0`, `mode=0`, `hsync=vsync=0` (`SYNC_ACTIVE=1`).
- Mode 0, `x_in` sweeps 0..1439 with `de_in=1` → 2 cycles later: white for x 0..179, yellow for 180..359, …, black for 1260..1439. `de_in=0` → `r/g/b=0`.
- Run with `DEBOUNCE_CYCLES=16`: key low for 10 cycles then high → `mode` stays 0. Key low for 20 cycles, then frame start → `mode=1` in that cycle, no earlier.
- Three valid presses within one frame → `mode` increments once. Four separate frames each with one press → `mode` sequence 1,2,3,0.
- Mode 2, `CHECK_LOG2=5`: pixel (32,0) is white, (32,32) is black, (0,0) is black. Mode 3: pixel (0,500) is white, (700,500) is `b=16`.
- With `VGA_PATTERN_ANIMATE_EN`, mode 1, after 4 frame starts: pixel x=0 gives `g=1` (x+4=4 → `g=4>>2`).
